// File: rtl/dec_onehot_seq_if.sv
// Control/strobe bundle between a controller and the registered one-hot decoder.
// The controller drives the command side; the decoder returns the strobe and its state.
interface dec_onehot_seq_if #(
   parameter int unsigned SEL_W = 3
);
   localparam int unsigned OUT_W = 1 << SEL_W;

   logic             en;
   logic             clr;
   logic             load;
   logic [SEL_W-1:0] sel;
   logic             step;
   logic [OUT_W-1:0] out;
   logic [SEL_W-1:0] cur;
   logic             active;
   logic             wrap;

   modport master (
      output en, clr, load, sel, step,
      input  out, cur, active, wrap
   );

   modport slave (
      input  en, clr, load, sel, step,
      output out, cur, active, wrap
   );
endinterface

// File: rtl/dec_onehot_seq.sv
// Registered binary-to-one-hot decoder with load, auto-step, clear and wrap pulse.
// PULSE=0 holds the strobe until changed; PULSE=1 strobes once per load/step.
module dec_onehot_seq #(
   parameter int unsigned SEL_W = 3,
   parameter bit          PULSE = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   dec_onehot_seq_if.slave     bus
);
   localparam int unsigned OUT_W = 1 << SEL_W;

   logic [SEL_W-1:0] idx_q, idx_d;
   logic             act_q, act_d;
   logic             wrap_q, wrap_d;

   // Priority: clr > load > step > idle. A step wraps when leaving the top index.
   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
      idx_d  = idx_q;
      act_d  = PULSE ? 1'b0 : act_q;
      wrap_d = 1'b0;
      if (bus.clr) begin
         idx_d = '0;
         act_d = 1'b0;
      end else if (bus.load) begin
         idx_d = bus.sel;
         act_d = 1'b1;
      end else if (bus.step) begin
         idx_d  = idx_q + 1'b1;
         act_d  = 1'b1;
         wrap_d = &idx_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         act_q  <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all state updates see pre-edge values.
         idx_q  <= idx_d;
         act_q  <= act_d;
         wrap_q <= wrap_d;
      end
   end

   // en gates the strobe combinationally and never touches state.
   assign bus.out    = (act_q && bus.en) ? (OUT_W'(1) << idx_q) : '0;
   assign bus.cur    = idx_q;
   assign bus.active = act_q;
   assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_dec_onehot_seq.sv
// Directed bench for dec_onehot_seq: hold mode (SEL_W=3), pulse mode (SEL_W=3)
// and the minimum width (SEL_W=1), each with hand-computed expected values.
module tb_dec_onehot_seq;
   typedef logic [31:0] w32_t;

   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   dec_onehot_seq_if #(.SEL_W(3)) h_if ();
   dec_onehot_seq_if #(.SEL_W(3)) p_if ();
   dec_onehot_seq_if #(.SEL_W(1)) s_if ();

   dec_onehot_seq #(.SEL_W(3), .PULSE(1'b0)) u_hold  (.clk(clk), .rst_n(rst_n), .bus(h_if.slave));
   dec_onehot_seq #(.SEL_W(3), .PULSE(1'b1)) u_pulse (.clk(clk), .rst_n(rst_n), .bus(p_if.slave));
   dec_onehot_seq #(.SEL_W(1), .PULSE(1'b0)) u_small (.clk(clk), .rst_n(rst_n), .bus(s_if.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected summary");
      $fatal(1, "time limit reached");
   end

   task automatic check(input string tag, input w32_t obs, input w32_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_h(input string tag, input w32_t e_out, input w32_t e_cur,
                        input w32_t e_act, input w32_t e_wrap);
      check({tag, "/out"},    32'(h_if.out),    e_out);
      check({tag, "/cur"},    32'(h_if.cur),    e_cur);
      check({tag, "/active"}, 32'(h_if.active), e_act);
      check({tag, "/wrap"},   32'(h_if.wrap),   e_wrap);
   endtask

   task automatic chk_p(input string tag, input w32_t e_out, input w32_t e_cur,
                        input w32_t e_act, input w32_t e_wrap);
      check({tag, "/out"},    32'(p_if.out),    e_out);
      check({tag, "/cur"},    32'(p_if.cur),    e_cur);
      check({tag, "/active"}, 32'(p_if.active), e_act);
      check({tag, "/wrap"},   32'(p_if.wrap),   e_wrap);
   endtask

   task automatic chk_s(input string tag, input w32_t e_out, input w32_t e_cur,
                        input w32_t e_act, input w32_t e_wrap);
      check({tag, "/out"},    32'(s_if.out),    e_out);
      check({tag, "/cur"},    32'(s_if.cur),    e_cur);
      check({tag, "/active"}, 32'(s_if.active), e_act);
      check({tag, "/wrap"},   32'(s_if.wrap),   e_wrap);
   endtask

   // Inputs change at the falling edge; outputs are sampled there too.
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      h_if.en = 1'b0; h_if.clr = 1'b0; h_if.load = 1'b1; h_if.sel = 3'd5; h_if.step = 1'b0;
      p_if.en = 1'b0; p_if.clr = 1'b0; p_if.load = 1'b0; p_if.sel = 3'd0; p_if.step = 1'b0;
      s_if.en = 1'b0; s_if.clr = 1'b0; s_if.load = 1'b0; s_if.sel = 1'b0; s_if.step = 1'b0;

      // Reset holds everything at zero even with load asserted and the clock running.
      #1 chk_h("rst_t0", 0, 0, 0, 0);
      cycle();
      cycle();
      chk_h("rst_hold", 0, 0, 0, 0);

      // Release mid-cycle; nothing happens until a load arrives.
      h_if.load = 1'b0;
      #2 rst_n = 1'b1;
      cycle();
      cycle();
      chk_h("rst_rel", 0, 0, 0, 0);

      // Hold mode: load 3, then stays put for 4 idle cycles.
      h_if.en = 1'b1; h_if.load = 1'b1; h_if.sel = 3'd3;
      cycle();
      chk_h("load3", 32'h08, 3, 1, 0);
      h_if.load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk_h("hold3", 32'h08, 3, 1, 0);
      end

      // Sweep across the top index: wrap only in the cycle showing bit 0.
      h_if.load = 1'b1; h_if.sel = 3'd6;
      cycle();
      chk_h("sweep6", 32'h40, 6, 1, 0);
      h_if.load = 1'b0; h_if.step = 1'b1;
      cycle();
      chk_h("sweep7", 32'h80, 7, 1, 0);
      cycle();
      chk_h("sweep0", 32'h01, 0, 1, 1);
      cycle();
      chk_h("sweep1", 32'h02, 1, 1, 0);
      h_if.step = 1'b0;
      cycle();
      chk_h("sweep_hold", 32'h02, 1, 1, 0);

      // load beats step: from idx 7 a step would wrap, load must not.
      h_if.load = 1'b1; h_if.sel = 3'd7;
      cycle();
      chk_h("pre7", 32'h80, 7, 1, 0);
      h_if.sel = 3'd2; h_if.step = 1'b1;
      cycle();
      chk_h("load_vs_step", 32'h04, 2, 1, 0);

      // clr beats load, and clr beats a wrapping step.
      h_if.clr = 1'b1; h_if.sel = 3'd5; h_if.step = 1'b0;
      cycle();
      chk_h("clr_vs_load", 0, 0, 0, 0);
      h_if.clr = 1'b0; h_if.sel = 3'd7;
      cycle();
      chk_h("pre7b", 32'h80, 7, 1, 0);
      h_if.load = 1'b0; h_if.clr = 1'b1; h_if.step = 1'b1;
      cycle();
      chk_h("clr_vs_step", 0, 0, 0, 0);

      // A step from inactive activates at idx+1.
      h_if.clr = 1'b0;
      cycle();
      chk_h("step_inact", 32'h02, 1, 1, 0);

      // en gating while the sweep keeps advancing.
      h_if.en = 1'b0;
      cycle();
      chk_h("en_off2", 0, 2, 1, 0);
      cycle();
      chk_h("en_off3", 0, 3, 1, 0);
      h_if.en = 1'b1;
      #1 chk_h("en_on3", 32'h08, 3, 1, 0);
      cycle();
      chk_h("en_on4", 32'h10, 4, 1, 0);

      // Asynchronous reset mid-sweep; no resume afterwards without a command.
      #2 rst_n = 1'b0;
      #1 chk_h("rst_mid", 0, 0, 0, 0);
      h_if.step = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      cycle();
      cycle();
      chk_h("rst_mid_rel", 0, 0, 0, 0);

      // Pulse mode: single-cycle strobes, continuous steps without gaps.
      p_if.en = 1'b1; p_if.load = 1'b1; p_if.sel = 3'd4;
      cycle();
      chk_p("p_load4", 32'h10, 4, 1, 0);
      p_if.load = 1'b0;
      cycle();
      chk_p("p_idle", 0, 4, 0, 0);
      p_if.step = 1'b1;
      cycle();
      chk_p("p_step5", 32'h20, 5, 1, 0);
      cycle();
      chk_p("p_step6", 32'h40, 6, 1, 0);
      p_if.step = 1'b0;
      cycle();
      chk_p("p_idle6", 0, 6, 0, 0);
      p_if.load = 1'b1; p_if.sel = 3'd7;
      cycle();
      chk_p("p_load7", 32'h80, 7, 1, 0);
      p_if.load = 1'b0; p_if.step = 1'b1;
      cycle();
      chk_p("p_wrap", 32'h01, 0, 1, 1);
      p_if.step = 1'b0;
      cycle();
      chk_p("p_after_wrap", 0, 0, 0, 0);

      // Minimum width: two outputs, a wrap pulse on every second step.
      s_if.en = 1'b1; s_if.step = 1'b1;
      cycle();
      chk_s("s_step1", 2'b10, 1, 1, 0);
      cycle();
      chk_s("s_wrap", 2'b01, 0, 1, 1);
      cycle();
      chk_s("s_step1b", 2'b10, 1, 1, 0);
      s_if.step = 1'b0;
      cycle();
      chk_s("s_hold", 2'b10, 1, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
